// File: rtl/xbar_2x2_router.sv
// rtl/xbar_2x2_router.sv - 2-master x 2-slave req/ack crossbar, one arbiter FSM per slave
// XBAR_RR_EN selects round-robin tie-break; without it m0 always wins ties.
module xbar_2x2_router #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_cmd,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_cmd,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s0_req,
    output logic [ADDR_W-1:0] s0_addr,
    output logic              s0_cmd,
    output logic [DATA_W-1:0] s0_wdata,
    input  logic              s0_ack,
    input  logic [DATA_W-1:0] s0_rdata,
    output logic              s1_req,
    output logic [ADDR_W-1:0] s1_addr,
    output logic              s1_cmd,
    output logic [DATA_W-1:0] s1_wdata,
    input  logic              s1_ack,
    input  logic [DATA_W-1:0] s1_rdata
);
    typedef enum logic [1:0] {IDLE, GRANT, RDATA} state_t;

    logic [1:0]        m_req;
    logic [1:0]        m_cmd;
    logic [1:0]        s_ack;
    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];

    assign m_req      = {m1_req, m0_req};
    assign m_cmd      = {m1_cmd, m0_cmd};
    assign s_ack      = {s1_ack, s0_ack};
    assign m_addr[0]  = m0_addr;
    assign m_addr[1]  = m1_addr;
    assign m_wdata[0] = m0_wdata;
    assign m_wdata[1] = m1_wdata;

    for (genvar k = 0; k < 2; k++) begin : g_slv
        localparam logic SEL = (k == 1);

        state_t            state_q, state_d;
        logic              owner_q, owner_d;
        logic [1:0]        want;
        logic              tie;
        logic              sreq, scmd, gack, grd;
        logic [ADDR_W-1:0] saddr;
        logic [DATA_W-1:0] swdata;

        assign want[0] = m_req[0] && (m_addr[0][ADDR_W-1] == SEL);
        assign want[1] = m_req[1] && (m_addr[1][ADDR_W-1] == SEL);

`ifdef XBAR_RR_EN
        logic last_q, last_d;
        assign tie = ~last_q;

        // last_grant resets to m1 so that m0 wins the first tie
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) last_q <= 1'b1;
            else         last_q <= last_d;
        end

        always_comb begin
            last_d = last_q;
            if (state_q == IDLE && (|want)) last_d = owner_d;
        end
`else
        assign tie = 1'b0;
`endif

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= IDLE;
                owner_q <= 1'b0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
            end
        end

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            sreq    = 1'b0;
            saddr   = '0;
            scmd    = 1'b0;
            swdata  = '0;
            gack    = 1'b0;
            grd     = 1'b0;
            case (state_q)
                IDLE: begin
                    if (|want) begin
                        owner_d = (want == 2'b11) ? tie : want[1];
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    // owner still targeting this slave, otherwise abort silently
                    if (want[owner_q]) begin
                        sreq   = 1'b1;
                        saddr  = m_addr[owner_q];
                        scmd   = m_cmd[owner_q];
                        swdata = m_wdata[owner_q];
                        if (s_ack[k]) begin
                            gack    = 1'b1;
                            state_d = m_cmd[owner_q] ? IDLE : RDATA;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RDATA: begin
                    grd     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign s0_req   = g_slv[0].sreq;
    assign s0_addr  = g_slv[0].saddr;
    assign s0_cmd   = g_slv[0].scmd;
    assign s0_wdata = g_slv[0].swdata;
    assign s1_req   = g_slv[1].sreq;
    assign s1_addr  = g_slv[1].saddr;
    assign s1_cmd   = g_slv[1].scmd;
    assign s1_wdata = g_slv[1].swdata;

    always_comb begin
        m0_ack   = (g_slv[0].gack && !g_slv[0].owner_q) || (g_slv[1].gack && !g_slv[1].owner_q);
        m1_ack   = (g_slv[0].gack &&  g_slv[0].owner_q) || (g_slv[1].gack &&  g_slv[1].owner_q);
        m0_rdata = '0;
        m1_rdata = '0;
        if (g_slv[0].grd && !g_slv[0].owner_q)      m0_rdata = s0_rdata;
        else if (g_slv[1].grd && !g_slv[1].owner_q) m0_rdata = s1_rdata;
        if (g_slv[0].grd && g_slv[0].owner_q)       m1_rdata = s0_rdata;
        else if (g_slv[1].grd && g_slv[1].owner_q)  m1_rdata = s1_rdata;
    end
endmodule

// File: tb/tb_xbar_2x2_router.sv
// tb/tb_xbar_2x2_router.sv - scoreboard bench for xbar_2x2_router
module tb_xbar_2x2_router;
    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_cmd, m0_ack, m1_req, m1_cmd, m1_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s0_req, s0_cmd, s0_ack, s1_req, s1_cmd, s1_ack;
    logic [31:0] s0_addr, s0_wdata, s0_rdata, s1_addr, s1_wdata, s1_rdata;

    xbar_2x2_router #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_cmd(s0_cmd), .s0_wdata(s0_wdata),
        .s0_ack(s0_ack), .s0_rdata(s0_rdata),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_cmd(s1_cmd), .s1_wdata(s1_wdata),
        .s1_ack(s1_ack), .s1_rdata(s1_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic cmd; logic [31:0] wdata;} grant_t;
    typedef struct {logic rd; logic [31:0] rdata;} ack_t;

    grant_t gq0[$], gq1[$];
    ack_t   aq0[$], aq1[$];
    int     checks = 0;
    int     errors = 0;
    logic   pend[2] = '{1'b0, 1'b0};
    logic [31:0] pdata[2];
    logic   prev_req[2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic req, input logic [31:0] addr,
                           input logic cmd, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_addr = addr; m0_cmd = cmd; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_addr = addr; m1_cmd = cmd; m1_wdata = wdata;
        end
    endtask

    task automatic exp_grant(input int k, input logic [31:0] addr, input logic cmd,
                             input logic [31:0] wdata);
        grant_t g;
        g.addr = addr; g.cmd = cmd; g.wdata = wdata;
        if (k == 0) gq0.push_back(g);
        else        gq1.push_back(g);
    endtask

    task automatic exp_ack(input int m, input logic rd, input logic [31:0] rdata);
        ack_t a;
        a.rd = rd; a.rdata = rdata;
        if (m == 0) aq0.push_back(a);
        else        aq1.push_back(a);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {26'd0, m0_ack, m1_ack, s0_req, s1_req, s0_cmd, s1_cmd}, 32'd0);
        chk({name, "_data"}, m0_rdata | m1_rdata | s0_addr | s1_addr | s0_wdata | s1_wdata, 32'd0);
    endtask

    task automatic mon_master(input int m, input logic ack, input logic [31:0] rd,
                              input logic any_sack);
        ack_t a;
        if (pend[m]) begin
            chk($sformatf("m%0d_rdata", m), rd, pdata[m]);
            pend[m] = 1'b0;
        end else begin
            chk($sformatf("m%0d_rdata_idle", m), rd, 32'd0);
        end
        if (ack) begin
            chk($sformatf("m%0d_ack_has_sack", m), {31'd0, any_sack}, 32'd1);
            if ((m == 0 && aq0.size() == 0) || (m == 1 && aq1.size() == 0)) begin
                chk($sformatf("m%0d_unexpected_ack", m), 32'd1, 32'd0);
            end else begin
                a = (m == 0) ? aq0.pop_front() : aq1.pop_front();
                checks++;
                if (a.rd) begin
                    pend[m]  = 1'b1;
                    pdata[m] = a.rdata;
                end
            end
        end
    endtask

    task automatic mon_slave(input int k, input logic req, input logic [31:0] addr,
                             input logic cmd, input logic [31:0] wdata);
        grant_t g;
        if (req && !prev_req[k]) begin
            if ((k == 0 && gq0.size() == 0) || (k == 1 && gq1.size() == 0)) begin
                chk($sformatf("s%0d_unexpected_grant", k), addr, 32'hFFFF_FFFF);
            end else begin
                g = (k == 0) ? gq0.pop_front() : gq1.pop_front();
                chk($sformatf("s%0d_addr", k), addr, g.addr);
                chk($sformatf("s%0d_cmd", k), {31'd0, cmd}, {31'd0, g.cmd});
                chk($sformatf("s%0d_wdata", k), wdata, g.wdata);
            end
        end
        if (!req) chk($sformatf("s%0d_idle_zero", k), addr | wdata | {31'd0, cmd}, 32'd0);
        prev_req[k] = req;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_master(0, m0_ack, m0_rdata, s0_ack | s1_ack);
            mon_master(1, m1_ack, m1_rdata, s0_ack | s1_ack);
            mon_slave(0, s0_req, s0_addr, s0_cmd, s0_wdata);
            mon_slave(1, s1_req, s1_addr, s1_cmd, s1_wdata);
        end
    end

    initial begin
        resetn = 1'b0;
        drive_m(0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0);
        s0_ack = 0; s1_ack = 0; s0_rdata = 0; s1_rdata = 0;
        #3 chk_all_zero("reset_outs");
        tick(2);
        resetn = 1'b1;
        tick(1);
        chk_all_zero("post_reset_outs");

        // single write to s0, acked two cycles after s0_req
        drive_m(0, 1, 32'h0000_0005, 1, 32'hA5A5_A5A5);
        exp_grant(0, 32'h0000_0005, 1, 32'hA5A5_A5A5);
        exp_ack(0, 0, 0);
        chk("t1_no_comb_req", {31'd0, s0_req}, 32'd0);
        tick(1);
        chk("t1_s0_req_latency", {31'd0, s0_req}, 32'd1);
        chk("t1_s1_idle", {31'd0, s1_req}, 32'd0);
        tick(2);
        s0_ack = 1;
        tick(1);
        s0_ack = 0;
        drive_m(0, 0, 0, 0, 0);
        tick(2);

        // read from s1, rdata the cycle after ack
        drive_m(1, 1, 32'h8000_0003, 0, 32'h0);
        exp_grant(1, 32'h8000_0003, 0, 32'h0);
        exp_ack(1, 1, 32'h1234_5678);
        tick(1);
        s1_ack = 1;
        tick(1);
        s1_ack = 0;
        drive_m(1, 0, 0, 0, 0);
        s1_rdata = 32'h1234_5678;
        tick(1);
        s1_rdata = 0;
        tick(2);

        // parallel: m0 writes s0, m1 reads s1, acks on both slaves together
        drive_m(0, 1, 32'h0000_0001, 1, 32'h0000_0011);
        drive_m(1, 1, 32'h8000_0001, 0, 32'h0);
        exp_grant(0, 32'h0000_0001, 1, 32'h0000_0011);
        exp_grant(1, 32'h8000_0001, 0, 32'h0);
        exp_ack(0, 0, 0);
        exp_ack(1, 1, 32'hCAFE_F00D);
        tick(1);
        chk("t4_both_req", {30'd0, s1_req, s0_req}, 32'd3);
        s0_ack = 1; s1_ack = 1;
        tick(1);
        s0_ack = 0; s1_ack = 0;
        drive_m(0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0);
        s1_rdata = 32'hCAFE_F00D;
        tick(1);
        s1_rdata = 0;
        tick(2);

        // abort: m0 drops req mid-GRANT
        drive_m(0, 1, 32'h0000_0008, 1, 32'h0000_0066);
        exp_grant(0, 32'h0000_0008, 1, 32'h0000_0066);
        tick(2);
        drive_m(0, 0, 32'h0000_0008, 1, 32'h0000_0066);
        #1;
        chk("t6_req_falls", {31'd0, s0_req}, 32'd0);
        chk("t6_no_ack", {31'd0, m0_ack}, 32'd0);
        tick(1);
        chk("t6_stays_idle", {31'd0, s0_req}, 32'd0);
        tick(1);

        // reset while m1 owns s0
        drive_m(1, 1, 32'h0000_0040, 1, 32'h0000_0055);
        exp_grant(0, 32'h0000_0040, 1, 32'h0000_0055);
        tick(2);
        chk("t5_m1_granted", s0_addr, 32'h0000_0040);
        #1 resetn = 1'b0;
        drive_m(1, 0, 0, 0, 0);
        #1 chk_all_zero("t5_async_reset");
        tick(1);
        resetn = 1'b1;
        tick(1);

        // continuous contention on s0, each grant acked immediately
        drive_m(0, 1, 32'h0000_0010, 1, 32'h0000_0100);
        drive_m(1, 1, 32'h0000_0020, 1, 32'h0000_0200);
        s0_ack = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef XBAR_RR_EN
            if (i % 2 == 0) begin
                exp_grant(0, 32'h0000_0010, 1, 32'h0000_0100);
                exp_ack(0, 0, 0);
            end else begin
                exp_grant(0, 32'h0000_0020, 1, 32'h0000_0200);
                exp_ack(1, 0, 0);
            end
`else
            exp_grant(0, 32'h0000_0010, 1, 32'h0000_0100);
            exp_ack(0, 0, 0);
`endif
        end
        tick(8);
        drive_m(0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0);
        s0_ack = 0;
        tick(3);

        chk("gq0_drained", gq0.size(), 32'd0);
        chk("gq1_drained", gq1.size(), 32'd0);
        chk("aq0_drained", aq0.size(), 32'd0);
        chk("aq1_drained", aq1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
